// File: rtl/conv_operand_streamer.sv
// Producer side of the a/b operand handshake for the convolution controller.
// Walks x, y, ch_in, ch_out, k_v, k_h (k_h innermost), fetching one activation and one weight per MAC.
module conv_operand_streamer #(
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned INPUT_NB_CHANNELS  = 64,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned KERNEL_SIZE        = 3,
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned ACT_ADDR_WIDTH     = 26,
  parameter int unsigned WGT_ADDR_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      act_re,
  output logic [ACT_ADDR_WIDTH-1:0] act_addr,
  input  logic [DATA_WIDTH-1:0]     act_rdata,
  output logic                      wgt_re,
  output logic [WGT_ADDR_WIDTH-1:0] wgt_addr,
  input  logic [DATA_WIDTH-1:0]     wgt_rdata,
  output logic                      a_valid,
  input  logic                      a_ready,
  output logic [DATA_WIDTH-1:0]     a_data,
  output logic                      b_valid,
  input  logic                      b_ready,
  output logic [DATA_WIDTH-1:0]     b_data
);

  localparam int unsigned XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int unsigned YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int unsigned CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
  localparam int unsigned COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int unsigned KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1;
  localparam int          PAD = int'(KERNEL_SIZE / 2);

  localparam logic [XW-1:0]  X_LAST  = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [CIW-1:0] CI_LAST = CIW'(INPUT_NB_CHANNELS - 1);
  localparam logic [COW-1:0] CO_LAST = COW'(OUTPUT_NB_CHANNELS - 1);
  localparam logic [KW-1:0]  K_LAST  = KW'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_A, S_CAPT_A, S_SEND_A, S_ISSUE_B, S_CAPT_B, S_SEND_B, S_DONE
  } state_t;

  state_t r_state;

  logic [XW-1:0]  r_x,  w_nx,  w_sx;
  logic [YW-1:0]  r_y,  w_ny,  w_sy;
  logic [CIW-1:0] r_ci, w_nci, w_sci;
  logic [COW-1:0] r_co, w_nco, w_sco;
  logic [KW-1:0]  r_kv, w_nkv, w_skv;
  logic [KW-1:0]  r_kh, w_nkh, w_skh;
  logic           w_last;

  logic                      r_pad, w_pad, w_use_nxt;
  int                        w_xx, w_yy;
  logic [ACT_ADDR_WIDTH-1:0] w_act_addr;
  logic [WGT_ADDR_WIDTH-1:0] w_wgt_addr;

  logic                      r_busy, r_done, r_act_re, r_wgt_re;
  logic [ACT_ADDR_WIDTH-1:0] r_act_addr;
  logic [WGT_ADDR_WIDTH-1:0] r_wgt_addr;
  logic                      r_a_valid, r_b_valid;
  logic [DATA_WIDTH-1:0]     r_a_data, r_b_data;

  // Loop-nest increment: k_h first, carries ripple outward to x.
  always_comb begin
    w_nx  = r_x;
    w_ny  = r_y;
    w_nci = r_ci;
    w_nco = r_co;
    w_nkv = r_kv;
    w_nkh = r_kh;
    w_last = (r_kh == K_LAST) && (r_kv == K_LAST) && (r_co == CO_LAST) &&
             (r_ci == CI_LAST) && (r_y == Y_LAST) && (r_x == X_LAST);
    if (r_kh != K_LAST) begin
      w_nkh = r_kh + KW'(1);
    end else begin
      w_nkh = '0;
      if (r_kv != K_LAST) begin
        w_nkv = r_kv + KW'(1);
      end else begin
        w_nkv = '0;
        if (r_co != CO_LAST) begin
          w_nco = r_co + COW'(1);
        end else begin
          w_nco = '0;
          if (r_ci != CI_LAST) begin
            w_nci = r_ci + CIW'(1);
          end else begin
            w_nci = '0;
            if (r_y != Y_LAST) begin
              w_ny = r_y + YW'(1);
            end else begin
              w_ny = '0;
              w_nx = (r_x != X_LAST) ? r_x + XW'(1) : '0;
            end
          end
        end
      end
    end
  end

  // Addresses are computed for the MAC about to be issued: the next one when leaving SEND_B.
  always_comb begin
    w_use_nxt = (r_state == S_SEND_B);
    w_sx  = w_use_nxt ? w_nx  : r_x;
    w_sy  = w_use_nxt ? w_ny  : r_y;
    w_sci = w_use_nxt ? w_nci : r_ci;
    w_sco = w_use_nxt ? w_nco : r_co;
    w_skv = w_use_nxt ? w_nkv : r_kv;
    w_skh = w_use_nxt ? w_nkh : r_kh;
    w_xx  = int'(w_sx) + int'(w_skh) - PAD;
    w_yy  = int'(w_sy) + int'(w_skv) - PAD;
    w_pad = (w_xx < 0) || (w_yy < 0) ||
            (w_xx >= int'(FEATURE_MAP_WIDTH)) || (w_yy >= int'(FEATURE_MAP_HEIGHT));
    w_act_addr = ACT_ADDR_WIDTH'((64'(w_yy) * 64'(FEATURE_MAP_WIDTH) + 64'(w_xx)) *
                                 64'(INPUT_NB_CHANNELS) + 64'(w_sci));
    w_wgt_addr = WGT_ADDR_WIDTH'((((32'(w_sco) * INPUT_NB_CHANNELS + 32'(w_sci)) *
                                   KERNEL_SIZE + 32'(w_skv)) * KERNEL_SIZE) + 32'(w_skh));
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_ci       <= '0;
      r_co       <= '0;
      r_kv       <= '0;
      r_kh       <= '0;
      r_pad      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_act_re   <= 1'b0;
      r_act_addr <= '0;
      r_wgt_re   <= 1'b0;
      r_wgt_addr <= '0;
      r_a_valid  <= 1'b0;
      r_a_data   <= '0;
      r_b_valid  <= 1'b0;
      r_b_data   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_act_re   <= 1'b0;
      r_act_addr <= '0;
      r_wgt_re   <= 1'b0;
      r_wgt_addr <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ISSUE_A;
            r_busy     <= 1'b1;
            r_pad      <= w_pad;
            r_act_re   <= !w_pad;
            r_act_addr <= w_pad ? '0 : w_act_addr;
          end
        end
        S_ISSUE_A: r_state <= S_CAPT_A;
        S_CAPT_A: begin
          r_state   <= S_SEND_A;
          r_a_valid <= 1'b1;
          r_a_data  <= r_pad ? '0 : act_rdata;
        end
        S_SEND_A: begin
          if (r_a_valid && a_ready) begin
            r_state    <= S_ISSUE_B;
            r_a_valid  <= 1'b0;
            r_wgt_re   <= 1'b1;
            r_wgt_addr <= w_wgt_addr;
          end
        end
        S_ISSUE_B: r_state <= S_CAPT_B;
        S_CAPT_B: begin
          r_state   <= S_SEND_B;
          r_b_valid <= 1'b1;
          r_b_data  <= wgt_rdata;
        end
        S_SEND_B: begin
          if (r_b_valid && b_ready) begin
            r_b_valid <= 1'b0;
            r_x       <= w_nx;
            r_y       <= w_ny;
            r_ci      <= w_nci;
            r_co      <= w_nco;
            r_kv      <= w_nkv;
            r_kh      <= w_nkh;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_ISSUE_A;
              r_pad      <= w_pad;
              r_act_re   <= !w_pad;
              r_act_addr <= w_pad ? '0 : w_act_addr;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign act_re   = r_act_re;
  assign act_addr = r_act_addr;
  assign wgt_re   = r_wgt_re;
  assign wgt_addr = r_wgt_addr;
  assign a_valid  = r_a_valid;
  assign a_data   = r_a_data;
  assign b_valid  = r_b_valid;
  assign b_data   = r_b_data;

endmodule
